// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types for the trace capture path
package continuous_monitoring_system_pkg;

    localparam int DEFAULT_PC_WIDTH = 64;
    localparam int TRACE_ITEM_WIDTH = 64 + DEFAULT_PC_WIDTH;

    typedef struct packed {
        logic [31:0]                 delta;
        logic [31:0]                 instr;
        logic [DEFAULT_PC_WIDTH-1:0] pc;
    } trace_item_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } packer_state_t;

endpackage

// File: rtl/trace_item_fifo.sv
// rtl/trace_item_fifo.sv - first-word-fall-through FIFO holding packed trace items
module trace_item_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/trace_item_packer.sv
// rtl/trace_item_packer.sv - buffers filtered trace items and streams them as fixed-size packets
module trace_item_packer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int PACKET_ITEMS = 8,
    parameter int PC_WIDTH     = DEFAULT_PC_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pc_valid,
    input  logic [PC_WIDTH-1:0]           pc,
    input  logic [31:0]                   instr,
    input  logic                          drop_instr,
    input  logic                          flush,
    output logic [64+PC_WIDTH-1:0]        m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   overflow_count
);
    localparam int CNT_W = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    packer_state_t    state;
    logic [31:0]      delta_cnt;
    logic [CNT_W-1:0] pkt_cnt;
    logic             keep;
    logic             push;
    logic             lost;
    logic             beat;
    logic             full;
    logic             empty;
    logic             last_item;

    assign keep      = pc_valid & ~drop_instr;
    // Full is sampled before any same-cycle pop, and FLUSH refuses new items.
    assign push      = keep & ~full & (state == RUN);
    assign lost      = keep & ~push;
    assign beat      = m_axis_tvalid & m_axis_tready;
    assign last_item = (fifo_level == LVL_W'(1));

    assign m_axis_tvalid = ~empty;
    assign m_axis_tlast  = (pkt_cnt == CNT_W'(PACKET_ITEMS - 1)) |
                           ((state == FLUSH) & last_item);

    trace_item_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64 + PC_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({delta_cnt, instr, pc}),
        .pop   (beat),
        .dout  (m_axis_tdata),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            delta_cnt      <= '0;
            pkt_cnt        <= '0;
            overflow_count <= '0;
        end else begin
            if (push)                    delta_cnt <= 32'd1;
            else if (delta_cnt != '1)    delta_cnt <= delta_cnt + 32'd1;

            if (lost && overflow_count != '1) overflow_count <= overflow_count + 32'd1;

            if (beat) begin
                if (m_axis_tlast) pkt_cnt <= '0;
                else              pkt_cnt <= pkt_cnt + 1'b1;
            end

            case (state)
                // A flush that coincides with the final item leaving finds nothing to close.
                RUN:     if (flush && !empty && !(beat && last_item)) state <= FLUSH;
                FLUSH:   if (beat && last_item) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule
